amiga_clken_gen: RTL and testbench

- Parametrised successor to the chipset clock-enable generation that feeds minimig, TG68K glue and sdram_ctrl.
- Derives every chipset timing strobe (clk7_en, clk7n_en, c1, c3, cck, eclk) from one fast clock as clock enables; no derived clocks.
- Generalises the fixed 4:1 / 10-phase scheme to arbitrary divider ratios.
- Adds run/stall gating, phase resynchronisation and a lock indication.

---
 rtl/amiga_clk_pkg.sv | 19 +
 rtl/amiga_clken_gen_if.sv | 35 +++
 rtl/amiga_clken_gen_mod_counter.sv | 34 +++
 rtl/amiga_clken_gen.sv | 108 ++++++++++
 tb/tb_amiga_clken_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/amiga_clk_pkg.sv
// Shared constants and helpers for the chipset clock-enable generator.
//   CLK_DIV_DEF  : fast-clock cycles per 7 MHz period (default build)
//   CCK_DIV_DEF  : 7 MHz periods per colour-clock period
//   ECLK_LEN_DEF : 7 MHz periods per E-clock period
//   clog2_min1   : counter width that never collapses to zero bits
//   eclk_oh_t    : one-hot E-clock phase vector for the default build
package amiga_clk_pkg;

  localparam int CLK_DIV_DEF  = 4;
  localparam int CCK_DIV_DEF  = 2;
  localparam int ECLK_LEN_DEF = 10;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [ECLK_LEN_DEF-1:0] eclk_oh_t;

endpackage

// File: rtl/amiga_clken_gen_if.sv
// Control and timing-strobe bundle of the clock-enable generator.
//   master : drives run/stall/sync_req, observes the strobes
//   slave  : the generator itself
//   run, stall, sync_req          : counter control
//   clk7_en, clk7n_en, c1, c3     : 7 MHz enables and square waves
//   cck, eclk, phase, locked      : colour clock, E-clock one-hot, fast phase, lock
interface amiga_clken_gen_if
  import amiga_clk_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int ECLK_LEN = ECLK_LEN_DEF,
  parameter int PW       = $clog2(CLK_DIV)
);
  logic                run;
  logic                stall;
  logic                sync_req;
  logic                clk7_en;
  logic                clk7n_en;
  logic                c1;
  logic                c3;
  logic                cck;
  logic [ECLK_LEN-1:0] eclk;
  logic [PW-1:0]       phase;
  logic                locked;

  modport master (
    output run, stall, sync_req,
    input  clk7_en, clk7n_en, c1, c3, cck, eclk, phase, locked
  );

  modport slave (
    input  run, stall, sync_req,
    output clk7_en, clk7n_en, c1, c3, cck, eclk, phase, locked
  );
endinterface

// File: rtl/amiga_clken_gen_mod_counter.sv
// Modulo-N counter with increment and synchronous clear.
//   clk, rst : clock, async active-high reset
//   inc      : advance by one (wraps N-1 -> 0)
//   clr      : force to zero next edge (wins over inc)
//   value    : current count
//   wrap     : inc while at N-1 (combinational)
module mod_counter
  import amiga_clk_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);
  logic [W-1:0] value_q, value_d;

  assign wrap  = inc && (value_q == W'(N-1));
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr || wrap) value_d = '0;
    else if (inc)    value_d = value_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) value_q <= '0;
    else     value_q <= value_d;
endmodule

// File: rtl/amiga_clken_gen.sv
// Chipset timing strobes as clock enables derived from one fast clock.
//   clk, rst : fast clock, async active-high reset
//   bus      : slave side of amiga_clken_gen_if (run/stall/sync_req in,
//              clk7_en/clk7n_en/c1/c3/cck/eclk/phase/locked out)
// Counters: p = fast phase within a 7 MHz period, k = 7 MHz periods within
// a colour clock, e = 7 MHz periods within an E-clock. Every output is a
// registered decode of the next-state counters, so it lines up with the
// counter value it describes.
module amiga_clken_gen
  import amiga_clk_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int CCK_DIV  = CCK_DIV_DEF,
  parameter int ECLK_LEN = ECLK_LEN_DEF,
  parameter int PW       = $clog2(CLK_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  amiga_clken_gen_if.slave  bus
);
  localparam int PCW = clog2_min1(CLK_DIV);
  localparam int KW  = clog2_min1(CCK_DIV);
  localparam int EW  = clog2_min1(ECLK_LEN);

  logic           adv, w, clr_ke;
  logic [PCW-1:0] p, p_n;
  logic [KW-1:0]  k, k_n;
  logic [EW-1:0]  e, e_n;
  logic           k_wrap, e_wrap;

  logic                clk7_q, clk7_d, clk7n_q, clk7n_d;
  logic                c1_q, c1_d, c3_q, c3_d, cck_q, cck_d;
  logic [ECLK_LEN-1:0] eclk_q, eclk_d;
  logic [PW-1:0]       phase_q;
  logic                locked_q, locked_d, s_q, s_d;

  assign adv    = bus.run && !bus.stall;
  // A sync request landing on the wrap cycle itself is honoured there.
  assign clr_ke = w && (s_q || bus.sync_req);

  mod_counter #(.N(CLK_DIV)) u_p (
    .clk(clk), .rst(rst), .inc(adv), .clr(1'b0), .value(p), .wrap(w)
  );
  mod_counter #(.N(CCK_DIV)) u_k (
    .clk(clk), .rst(rst), .inc(w), .clr(clr_ke), .value(k), .wrap(k_wrap)
  );
  mod_counter #(.N(ECLK_LEN)) u_e (
    .clk(clk), .rst(rst), .inc(w), .clr(clr_ke), .value(e), .wrap(e_wrap)
  );

  always_comb begin
    p_n = p;
    if (w)        p_n = '0;
    else if (adv) p_n = p + 1'b1;

    k_n = k;
    if (clr_ke || k_wrap) k_n = '0;
    else if (w)           k_n = k + 1'b1;

    e_n = e;
    if (clr_ke || e_wrap) e_n = '0;
    else if (w)           e_n = e + 1'b1;

    clk7_d  = adv && (p_n == '0);
    clk7n_d = adv && (p_n == PCW'(CLK_DIV/2));
    c1_d    = (p_n < PCW'(CLK_DIV/2));
    c3_d    = (p_n >= PCW'(CLK_DIV/4)) && (p_n < PCW'(3*CLK_DIV/4));
    cck_d   = (k_n < KW'(CCK_DIV/2));
    for (int i = 0; i < ECLK_LEN; i++)
      eclk_d[i] = clk7_d && (e_n == EW'(i));

    // Lock on the first natural E-clock wrap; only reset drops it.
    locked_d = locked_q || e_wrap;
    s_d      = (s_q || bus.sync_req) && !w;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk7_q   <= 1'b0;
      clk7n_q  <= 1'b0;
      c1_q     <= 1'b0;
      c3_q     <= 1'b0;
      cck_q    <= 1'b0;
      eclk_q   <= '0;
      phase_q  <= '0;
      locked_q <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      clk7_q   <= clk7_d;
      clk7n_q  <= clk7n_d;
      c1_q     <= c1_d;
      c3_q     <= c3_d;
      cck_q    <= cck_d;
      eclk_q   <= eclk_d;
      phase_q  <= PW'(p_n);
      locked_q <= locked_d;
      s_q      <= s_d;
    end

  assign bus.clk7_en  = clk7_q;
  assign bus.clk7n_en = clk7n_q;
  assign bus.c1       = c1_q;
  assign bus.c3       = c3_q;
  assign bus.cck      = cck_q;
  assign bus.eclk     = eclk_q;
  assign bus.phase    = phase_q;
  assign bus.locked   = locked_q;
endmodule

// File: tb/tb_amiga_clken_gen.sv
module tb_amiga_clken_gen;
  import amiga_clk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  amiga_clken_gen_if #(.CLK_DIV(4), .ECLK_LEN(10)) bus ();
  amiga_clken_gen_if #(.CLK_DIV(8), .ECLK_LEN(6))  bus2 ();

  amiga_clken_gen u_dut (.clk(clk), .rst(rst), .bus(bus));
  amiga_clken_gen #(.CLK_DIV(8), .CCK_DIV(4), .ECLK_LEN(6)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    int       t;
    eclk_oh_t oh;
    logic     cck;
    logic     lk;
  } pulse_t;

  pulse_t pq[$];
  int     nq[$];

  // pulse-level expectation state (default build)
  int   e_m, k_m;
  logic lock_m, sync_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Queue n clk7_en pulses starting at t0 every 4 cycles; the clk7n_en
  // before the first pulse is at n7, later ones 2 cycles before each pulse.
  task automatic push_run(input int t0, input int n, input int n7);
    pulse_t pe;
    for (int i = 0; i < n; i++) begin
      pe.t = t0 + 4*i;
      if (e_m == 9) lock_m = 1'b1;
      if (sync_m) begin
        e_m = 0; k_m = 0; sync_m = 1'b0;
      end else begin
        e_m = (e_m + 1) % 10;
        k_m = (k_m + 1) % 2;
      end
      pe.oh = '0;
      pe.oh[e_m] = 1'b1;
      pe.cck = (k_m == 0);
      pe.lk  = lock_m;
      pq.push_back(pe);
      nq.push_back((i == 0) ? n7 : pe.t - 2);
    end
  endtask

  function automatic logic [17:0] outs1();
    return {bus.clk7_en, bus.clk7n_en, bus.c1, bus.c3, bus.cck,
            bus.eclk, bus.phase, bus.locked};
  endfunction

  function automatic logic [14:0] outs2();
    return {bus2.clk7_en, bus2.clk7n_en, bus2.c1, bus2.c3, bus2.cck,
            bus2.eclk, bus2.phase, bus2.locked};
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a strobe.
  always @(negedge clk) begin
    pulse_t pe;
    if (!rst) begin
      if (bus.clk7_en) begin
        if (pq.size() == 0) chk("clk7_en unexpected", bus.clk7_en, 0);
        else begin
          pe = pq.pop_front();
          chk("clk7_en cycle", cyc, pe.t);
          chk("eclk", bus.eclk, pe.oh);
          chk("cck", bus.cck, pe.cck);
          chk("locked", bus.locked, pe.lk);
          chk("c1/c3/phase at clk7_en", {bus.c1, bus.c3, bus.phase}, 4'b1000);
        end
      end else if (bus.eclk != '0) begin
        chk("eclk without clk7_en", bus.eclk, 0);
      end
      if (bus.clk7n_en) begin
        if (nq.size() == 0) chk("clk7n_en unexpected", bus.clk7n_en, 0);
        else begin
          chk("clk7n_en cycle", cyc, nq.pop_front());
          chk("c1/c3/phase at clk7n_en", {bus.c1, bus.c3, bus.phase}, 4'b0110);
        end
      end
    end
  end

  initial begin
    int r, r2, t;
    rst = 1'b1;
    bus.run = 1'b1;  bus.stall = 1'b0;  bus.sync_req = 1'b0;
    bus2.run = 1'b1; bus2.stall = 1'b0; bus2.sync_req = 1'b0;
    e_m = 0; k_m = 0; lock_m = 1'b0; sync_m = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset outputs", outs1(), 0);
    chk("reset outputs dut2", outs2(), 0);
    rst = 1'b0;
    r = cyc;
    push_run(r + 4, 12, r + 2);

    fork
      begin
        // free run: pulses every 4, lock at release+40
        t = r + 48;
        wait_cyc(t);
        // stall 3 cycles while p==3
        push_run(t + 7, 6, t + 2);
        wait_cyc(t + 3); bus.stall = 1'b1;
        wait_cyc(t + 6); bus.stall = 1'b0;
        t = t + 27;
        wait_cyc(t);
        // advance to e==6
        push_run(t + 4, 8, t + 2);
        t = t + 32;
        wait_cyc(t);
        // sync with e==6: next pulse is eclk[0], cck high; second request absorbed
        sync_m = 1'b1;
        push_run(t + 4, 6, t + 2);
        wait_cyc(t + 1); bus.sync_req = 1'b1;
        wait_cyc(t + 3); bus.sync_req = 1'b0;
        t = t + 24;
        wait_cyc(t);
        // freeze at p==1 for 10 cycles (k==1 -> cck low)
        push_run(t + 14, 3, t + 12);
        wait_cyc(t + 1); bus.run = 1'b0;
        for (int c = 2; c <= 11; c++) begin
          wait_cyc(t + c);
          chk("frozen outputs",
              {bus.clk7_en, bus.clk7n_en, bus.eclk, bus.c1, bus.c3, bus.phase, bus.cck},
              {2'b00, 10'h000, 1'b1, 1'b1, 2'd1, 1'b0});
        end
        bus.run = 1'b1;
        t = t + 22;
        // async reset mid-period (p==1, c1/c3 high beforehand)
        wait_cyc(t + 1);
        #2 rst = 1'b1;
        #1 chk("async reset outputs", outs1(), 0);
        wait_cyc(t + 4);
        rst = 1'b0;
        r2 = cyc;
        e_m = 0; k_m = 0; lock_m = 1'b0; sync_m = 1'b0;
        push_run(r2 + 4, 12, r2 + 2);
        wait_cyc(r2 + 39);
        chk("locked before 40", bus.locked, 0);
        wait_cyc(r2 + 48);
        bus.run = 1'b0;
        wait_cyc(r2 + 52);
      end
      begin
        // CLK_DIV=8, CCK_DIV=4, ECLK_LEN=6 instance, hand formulas
        for (int c = 1; c <= 100; c++) begin
          int p, k, e;
          logic [5:0]  oh;
          logic        c7;
          logic [14:0] ex;
          wait_cyc(r + c);
          p = c % 8; k = (c / 8) % 4; e = (c / 8) % 6;
          c7 = (p == 0);
          oh = '0;
          if (c7) oh[e] = 1'b1;
          ex = {c7, (p == 4), (p < 4), (p >= 2 && p < 6), (k < 2), oh,
                3'(p), (c >= 48)};
          chk("dut2 strobes", outs2(), ex);
        end
      end
    join

    chk("clk7_en pulses outstanding", pq.size(), 0);
    chk("clk7n_en pulses outstanding", nq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
